// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset PC, NOP encoding and the queue entry type for the fetch unit.
package ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } ifu_entry_t;
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: imem request/response, core output and redirect channels of the fetch unit.
interface ifu_fetch_if;
  import ifu_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with registered storage; flush wins over a same-cycle push or pop.
module ifu_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign do_push = push_i && !flush_i;
  assign do_pop = pop_i && (count_q != '0) && !flush_i;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= inc(wptr_q);
      if (do_pop) rptr_q <= inc(rptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata_i;
  always_ff @(posedge clk)
    if (reset) assert (!(do_push && count_q == CW'(DEPTH)));
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: credit-limited sequential fetch, in-order response tagging and redirect flush.
// Define IFU_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module ifu_fetch import ifu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int QDEPTH = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  ifu_fetch_if.master bus,
  output logic        busy
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int QW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc;
  logic [OW-1:0] osd_q, osd_d, drop_q, drop_d, tcount;
  logic [QW-1:0] qcount;
  logic run_q, req_v, out_v, acc, rsp, keep, deq, redir;
  ifu_entry_t head;
  assign redir = bus.redirect_valid;
  assign rsp = bus.imem_resp_valid;
  // osd_q also covers responses owed to a flushed stream, so a slot is always free for each one
  assign req_v = run_q && !redir && int'(osd_q) < MAX_OUTST && int'(osd_q) + int'(qcount) < QDEPTH;
  assign acc = req_v && bus.imem_req_ready;
  assign keep = rsp && drop_q == '0;
  assign out_v = qcount != '0;
  assign deq = out_v && bus.out_ready;
  always_comb begin
    fetch_pc_d = redir ? (bus.redirect_pc & ~32'h3) : acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    osd_d = osd_q + OW'(acc) - OW'(rsp);
    drop_d = redir ? osd_d : drop_q - OW'(rsp && drop_q != '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      osd_q <= '0;
      drop_q <= '0;
      run_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      osd_q <= osd_d;
      drop_q <= drop_d;
      run_q <= 1'b1;
    end
  ifu_fifo #(.W($bits(ifu_entry_t)), .DEPTH(QDEPTH)) u_iq (
    .clk(clk), .reset(reset), .flush_i(redir), .push_i(keep), .pop_i(deq),
    .wdata_i({bus.imem_resp_data, tag_pc}), .rdata_o(head), .count_o(qcount)
  );
  // tags are never flushed: a dropped response still consumes its tag
  ifu_fifo #(.W(XLEN), .DEPTH(MAX_OUTST)) u_tq (
    .clk(clk), .reset(reset), .flush_i(1'b0), .push_i(acc), .pop_i(rsp),
    .wdata_i(fetch_pc_q), .rdata_o(tag_pc), .count_o(tcount)
  );
  always_ff @(posedge clk)
    if (reset) assert (tcount == osd_q);
  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr = fetch_pc_q;
  assign bus.out_valid = out_v;
  assign bus.out_inst = out_v ? head.inst : '0;
  assign bus.out_pc = out_v ? head.pc : '0;
  assign busy = osd_q != '0 || drop_q != '0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (deq) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (bus.out_ready && !out_v) perf_stall_q <= perf_stall_q + 32'd1;
    end
  assign perf_fetched = perf_fetched_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized fetch stream against a queue-based memory/program-order model, plus redirect vectors.
module tb_ifu_fetch;
  import ifu_pkg::*;
  typedef struct {
    logic [31:0] addr;
    int due;
  } mreq_t;
  typedef struct {
    logic [31:0] rpc;
    logic [31:0] first;
    logic [31:0] second;
  } rvec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  int m_fetched, m_stall;
`endif
  ifu_fetch_if bus();
  ifu_fetch dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc_n = 0, last_due = 0;
  int p_rdy = 100, p_ordy = 100, lat_lo = 1, lat_hi = 1, acc_n = 0, first_ov, n;
  mreq_t memq[$];
  logic [31:0] got[$];
  logic [31:0] exp_fetch, exp_out, prev_addr, ra_s, a0;
  logic prev_stall, ov_s, rv_s, seen;
  rvec_t tbl[4];
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (step %0d)", name, act, exp_v, cyc_n);
    end
  endtask
  task automatic model_reset();
    memq.delete();
    got.delete();
    exp_fetch = 32'h8000_0000;
    exp_out = 32'h8000_0000;
    prev_stall = 1'b0;
    last_due = cyc_n;
`ifdef IFU_PERF_CNT_EN
    m_fetched = 0;
    m_stall = 0;
`endif
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, bus.imem_req_addr, 32'h8000_0000);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_inst"}, bus.out_inst, 32'd0);
    chk({tag, "_out_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
  endtask
  // rmode: 0 none, 1 forced, 2 only when a response and a valid head coincide, 3 random 5%
  task automatic step(input int rmode, input logic [31:0] rpc);
    logic rd, due, acc, deq;
    int lat;
    @(negedge clk);
    cyc_n++;
    due = memq.size() != 0;
    if (due) due = memq[0].due <= cyc_n;
    rd = rmode == 1 || (rmode == 2 && due && bus.out_valid) || (rmode == 3 && $urandom_range(99) < 5);
    bus.imem_req_ready = $urandom_range(99) < p_rdy;
    bus.out_ready = $urandom_range(99) < p_ordy;
    bus.redirect_valid = rd;
    bus.redirect_pc = rpc;
    bus.imem_resp_valid = due;
    bus.imem_resp_data = $urandom;
    if (due) bus.imem_resp_data = mem_fn(memq[0].addr);
    #1;
    ov_s = bus.out_valid;
    rv_s = bus.imem_req_valid;
    ra_s = bus.imem_req_addr;
    chk("busy", 32'(busy), 32'(memq.size() != 0));
    if (rd) chk("no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
    else if (prev_stall) begin
      chk("req_held", 32'(bus.imem_req_valid), 32'd1);
      chk("addr_held", bus.imem_req_addr, prev_addr);
    end
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_fetch);
    if (bus.out_valid) begin
      chk("out_pc", bus.out_pc, exp_out);
      chk("out_inst", bus.out_inst, mem_fn(exp_out));
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_stall", perf_stall, 32'(m_stall));
    if (bus.out_ready && !bus.out_valid) m_stall++;
`endif
    acc = bus.imem_req_valid && bus.imem_req_ready;
    deq = bus.out_valid && bus.out_ready;
    prev_stall = bus.imem_req_valid && !bus.imem_req_ready && !rd;
    prev_addr = bus.imem_req_addr;
    if (deq) begin
      got.push_back(bus.out_pc);
      exp_out += 32'd4;
`ifdef IFU_PERF_CNT_EN
      m_fetched++;
`endif
    end
    if (due) void'(memq.pop_front());
    if (acc) begin
      acc_n++;
      lat = int'($urandom_range(lat_hi, lat_lo));
      last_due = (cyc_n + lat > last_due) ? cyc_n + lat : last_due + 1;
      memq.push_back('{bus.imem_req_addr, last_due});
      exp_fetch += 32'd4;
    end
    if (rd) begin
      exp_fetch = rpc & ~32'h3;
      exp_out = exp_fetch;
    end
    @(posedge clk);
  endtask
  task automatic drain();
    #1;
    p_rdy = 0;
    p_ordy = 100;
    lat_lo = 1;
    lat_hi = 1;
    n = 0;
    while ((busy || bus.out_valid) && n < 50) begin
      step(0, 32'd0);
      #1;
      n++;
    end
    chk("drain", 32'(busy || bus.out_valid), 32'd0);
  endtask
  initial begin
    tbl[0] = '{32'h8000_0103, 32'h8000_0100, 32'h8000_0104};
    tbl[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[2] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
    tbl[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'h8000_0000};
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b1;
    first_ov = 0;
    for (int i = 1; i <= 10 && first_ov == 0; i++) begin
      step(0, 32'd0);
      if (ov_s) first_ov = i;
    end
    chk("first_out_latency", 32'(first_ov), 32'd3);
    got.delete();
    repeat (30) step(0, 32'd0);
    chk("stream_rate", 32'(got.size() >= 10), 32'd1);
    p_ordy = 0;
    acc_n = 0;
    repeat (10) step(0, 32'd0);
    #1;
    chk("stall_accepts", 32'(acc_n <= 2), 32'd1);
    chk("stall_req_low", 32'(bus.imem_req_valid), 32'd0);
    p_ordy = 100;
    repeat (10) step(0, 32'd0);
    drain();
    a0 = exp_fetch;
    repeat (5) step(0, 32'd0);
    #1;
    chk("ready_low_req", 32'(bus.imem_req_valid), 32'd1);
    chk("ready_low_addr", bus.imem_req_addr, a0);
    for (int i = 0; i < 4; i++) begin
      drain();
      p_rdy = 100;
      lat_lo = 4;
      lat_hi = 4;
      step(0, 32'd0);
      step(0, 32'd0);
      chk("two_outstanding", 32'(memq.size()), 32'd2);
      got.delete();
      step(1, tbl[i].rpc);
      #1;
      chk("drop_busy", 32'(busy), 32'd1);
      lat_lo = 1;
      lat_hi = 1;
      n = 0;
      while (got.size() < 2 && n < 40) begin
        step(0, 32'd0);
        n++;
      end
      chk("redir_delivered", 32'(got.size() >= 2), 32'd1);
      if (got.size() >= 2) begin
        chk("redir_first_pc", got[0], tbl[i].first);
        chk("redir_second_pc", got[1], tbl[i].second);
      end
    end
    p_rdy = 100;
    p_ordy = 100;
    lat_lo = 1;
    lat_hi = 1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step(2, 32'h8000_2000);
      if (bus.redirect_valid) begin
        seen = 1'b1;
        #1;
        chk("flush_empty", 32'(bus.out_valid), 32'd0);
      end
    end
    chk("redirect_with_resp_seen", 32'(seen), 32'd1);
    repeat (20) step(0, 32'd0);
    p_rdy = 70;
    p_ordy = 70;
    lat_lo = 1;
    lat_hi = 3;
    repeat (2000) step(3, $urandom);
    p_rdy = 100;
    p_ordy = 50;
    lat_lo = 2;
    lat_hi = 3;
    n = 0;
    do begin
      step(0, 32'd0);
      #1;
      n++;
    end while (!busy && n < 20);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset("mid");
    model_reset();
    bus.out_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(0, 32'd0);
    chk("restart_req", 32'(rv_s), 32'd1);
    chk("restart_addr", ra_s, 32'h8000_0000);
    p_ordy = 100;
    repeat (20) step(0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
